rc4_decrypt_check: RTL and testbench

Per-core RC4 keystream and plaintext-check stage. Starts once the key-schedule (shuffle) stage has left a permuted S array in the core's working RAM. Runs the RC4 PRGA over the encrypted-message ROM, XORs each keystream byte with ciphertext, writes plaintext to the decrypted-message RAM, and accepts/rejects the candidate key on character content. Its `done`/`valid` outputs drive the brute-force key sequencer and the cross-core stop logic.

---
 rtl/rc4_decrypt_check.sv | 182 ++++++++++++++++++
 tb/tb_rc4_decrypt_check.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_decrypt_check.sv
// RC4 PRGA keystream stage: decrypts the message ROM with the permuted S array
// held in working RAM and accepts the key only if every plaintext byte is a space or lowercase letter.
module rc4_decrypt_check #(
    parameter int MSG_LEN = 32,
    parameter int M_AW    = 5
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_start,
    input  logic            i_abort,
    output logic [7:0]      o_s_addr,
    output logic [7:0]      o_s_wdata,
    output logic            o_s_wren,
    input  logic [7:0]      i_s_rdata,
    output logic [M_AW-1:0] o_m_addr,
    input  logic [7:0]      i_m_rdata,
    output logic [M_AW-1:0] o_d_addr,
    output logic [7:0]      o_d_wdata,
    output logic            o_d_wren,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_valid,
    output logic [M_AW-1:0] o_fail_idx
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_I  = 3'd1,
        ST_RD_J  = 3'd2,
        ST_WR_I  = 3'd3,
        ST_WR_J  = 3'd4,
        ST_RD_F  = 3'd5,
        ST_CHECK = 3'd6,
        ST_FIN   = 3'd7
    } state_t;

    localparam logic [M_AW-1:0] LAST_K = M_AW'(MSG_LEN - 1);

    function automatic logic char_ok(input logic [7:0] p);
        return (p == 8'h20) || ((p >= 8'h61) && (p <= 8'h7A));
    endfunction

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_i;
    logic [7:0]      r_j;
    logic [7:0]      r_si;
    logic [7:0]      r_sj;
    logic [7:0]      r_enc;
    logic [M_AW-1:0] r_k;
    logic            r_valid;
    logic [M_AW-1:0] r_fail_idx;
    logic [7:0]      w_p;
    logic            w_pass;
    logic            w_last;
    logic            w_run_abort;

    assign w_p         = i_s_rdata ^ r_enc;
    assign w_pass      = char_ok(w_p);
    assign w_last      = (r_k == LAST_K);
    assign w_run_abort = i_abort && (r_state != ST_IDLE) && (r_state != ST_FIN);

    // Next-state selection; abort wins over start in IDLE and kills any active byte
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!i_abort && i_start) begin
                    w_next = ST_RD_I;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RD_I:  w_next = i_abort ? ST_IDLE : ST_RD_J;
            ST_RD_J:  w_next = i_abort ? ST_IDLE : ST_WR_I;
            ST_WR_I:  w_next = i_abort ? ST_IDLE : ST_WR_J;
            ST_WR_J:  w_next = i_abort ? ST_IDLE : ST_RD_F;
            ST_RD_F:  w_next = i_abort ? ST_IDLE : ST_CHECK;
            ST_CHECK: begin
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else if (w_pass && !w_last) begin
                    w_next = ST_RD_I;
                end else begin
                    w_next = ST_FIN;
                end
            end
            ST_FIN:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State register plus the PRGA index/swap datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_i        <= 8'h00;
            r_j        <= 8'h00;
            r_si       <= 8'h00;
            r_sj       <= 8'h00;
            r_enc      <= 8'h00;
            r_k        <= '0;
            r_valid    <= 1'b0;
            r_fail_idx <= '0;
        end else begin
            r_state <= w_next;
            if (w_run_abort) begin
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!i_abort && i_start) begin
                            r_i     <= 8'h00;
                            r_j     <= 8'h00;
                            r_k     <= '0;
                            r_valid <= 1'b0;
                        end
                    end
                    ST_RD_I: r_i <= r_i + 8'd1;
                    ST_RD_J: begin
                        r_si  <= i_s_rdata;
                        r_enc <= i_m_rdata;
                        r_j   <= r_j + i_s_rdata;
                    end
                    ST_WR_I: r_sj <= i_s_rdata;
                    ST_CHECK: begin
                        if (!w_pass) begin
                            r_fail_idx <= r_k;
                        end else if (w_last) begin
                            r_valid <= 1'b1;
                        end else begin
                            r_k <= r_k + {{(M_AW-1){1'b0}}, 1'b1};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Memory strobes are Moore decodes of the state; abort masks writes in the same cycle
    always_comb begin
        o_s_addr  = 8'h00;
        o_s_wdata = 8'h00;
        o_s_wren  = 1'b0;
        o_d_wdata = 8'h00;
        o_d_wren  = 1'b0;
        case (r_state)
            ST_RD_I: o_s_addr = r_i + 8'd1;
            ST_RD_J: o_s_addr = r_j + i_s_rdata;
            ST_WR_I: begin
                o_s_addr  = r_i;
                o_s_wdata = i_s_rdata;
                o_s_wren  = !i_abort;
            end
            ST_WR_J: begin
                o_s_addr  = r_j;
                o_s_wdata = r_si;
                o_s_wren  = !i_abort;
            end
            ST_RD_F: o_s_addr = r_si + r_sj;
            ST_CHECK: begin
                if (w_pass && !i_abort) begin
                    o_d_wdata = w_p;
                    o_d_wren  = 1'b1;
                end else begin
                    o_d_wdata = 8'h00;
                    o_d_wren  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign o_m_addr   = r_k;
    assign o_d_addr   = r_k;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_FIN);
    assign o_valid    = r_valid;
    assign o_fail_idx = r_fail_idx;

endmodule

// File: tb/tb_rc4_decrypt_check.sv
// Directed bench for rc4_decrypt_check: RAM/ROM models, cycle-accurate timing checks and an RC4 reference.
module tb_rc4_decrypt_check;
    localparam int MSG_LEN = 32;
    localparam int M_AW    = 5;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [7:0]      s_addr, s_wdata, s_rdata, m_rdata, d_wdata;
    logic            s_wren, d_wren, busy, done, valid;
    logic [M_AW-1:0] m_addr, d_addr, fail_idx;

    rc4_decrypt_check #(.MSG_LEN(MSG_LEN), .M_AW(M_AW)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_abort(abort),
        .o_s_addr(s_addr), .o_s_wdata(s_wdata), .o_s_wren(s_wren), .i_s_rdata(s_rdata),
        .o_m_addr(m_addr), .i_m_rdata(m_rdata),
        .o_d_addr(d_addr), .o_d_wdata(d_wdata), .o_d_wren(d_wren),
        .o_busy(busy), .o_done(done), .o_valid(valid), .o_fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    logic [7:0] s_mem [256];
    logic [7:0] m_rom [32];
    logic [7:0] ms [256];
    bit         mem_init = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Working RAM and message ROM, both with one cycle of read latency
    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < 256; a++) s_mem[a] <= 8'(a);
        end else if (s_wren) begin
            s_mem[s_addr] <= s_wdata;
        end
        s_rdata <= s_mem[s_addr];
        m_rdata <= m_rom[m_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int         wr_cyc [$];
    logic [7:0] wr_dat [$];
    logic [4:0] wr_adr [$];
    int         done_rel, done_cnt, late_wr;
    logic       done_valid, snap_busy, snap_nz;
    logic [4:0] done_fidx;

    task automatic init_mem();
        @(negedge clk);
        mem_init = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
    endtask

    task automatic start_run(output int t);
        @(negedge clk);
        start = 1'b1;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observe from cycle t+1 up to t+lim, injecting optional start/abort/reset pulses
    task automatic run_window(input int t, input int lim, input int pulse_at, input int abort_at,
                              input int rst_at, input int snap_at, input int late_from);
        wr_cyc.delete(); wr_dat.delete(); wr_adr.delete();
        done_rel = -1; done_cnt = 0; late_wr = 0;
        done_valid = 1'b0; done_fidx = 5'd0; snap_busy = 1'b1; snap_nz = 1'b1;
        while (cyc <= t + lim) begin
            start   = (pulse_at >= 0) && (cyc == t + pulse_at);
            abort   = (abort_at >= 0) && (cyc == t + abort_at);
            reset_n = !((rst_at >= 0) && (cyc == t + rst_at));
            #1;
            if (d_wren) begin
                wr_cyc.push_back(cyc - t);
                wr_dat.push_back(d_wdata);
                wr_adr.push_back(d_addr);
            end
            if ((late_from >= 0) && (cyc >= t + late_from) && (s_wren || d_wren)) late_wr++;
            if ((snap_at >= 0) && (cyc == t + snap_at)) begin
                snap_busy = busy;
                snap_nz = |{s_addr, s_wdata, s_wren, m_addr, d_addr, d_wdata, d_wren,
                            busy, done, valid, fail_idx};
            end
            if (done) begin
                done_cnt++;
                done_rel = cyc - t;
                done_valid = valid;
                done_fidx = fail_idx;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        int t;
        int bad;
        logic [7:0] mi, mj, tmp;

        for (int a = 0; a < 32; a++) m_rom[a] = 8'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("reset_outs", 32'(|{s_addr, s_wdata, s_wren, m_addr, d_addr, d_wdata, d_wren,
                                     busy, done, valid, fail_idx}), 32'd0);

        // Two passing bytes, third decrypts to 0x00 and is rejected
        m_rom[0] = 8'h63; m_rom[1] = 8'h66; m_rom[2] = 8'h07;
        init_mem();
        start_run(t);
        run_window(t, 400, -1, -1, -1, -1, -1);
        check_eq("t1_done_cyc", 32'(done_rel), 32'd19);
        check_eq("t1_valid", 32'(done_valid), 32'd0);
        check_eq("t1_fail_idx", 32'(done_fidx), 32'd2);
        check_eq("t1_nwr", 32'(wr_cyc.size()), 32'd2);
        if (wr_cyc.size() >= 2) begin
            check_eq("t1_wr0_cyc", 32'(wr_cyc[0]), 32'd6);
            check_eq("t1_wr0_dat", 32'(wr_dat[0]), 32'h61);
            check_eq("t1_wr0_adr", 32'(wr_adr[0]), 32'd0);
            check_eq("t1_wr1_cyc", 32'(wr_cyc[1]), 32'd12);
            check_eq("t1_wr1_dat", 32'(wr_dat[1]), 32'h63);
            check_eq("t1_wr1_adr", 32'(wr_adr[1]), 32'd1);
        end
        @(negedge clk);
        check_eq("t1_s2", 32'(s_mem[2]), 32'd3);
        check_eq("t1_s3", 32'(s_mem[3]), 32'd5);
        check_eq("t1_s5", 32'(s_mem[5]), 32'd2);

        // First byte fails immediately
        m_rom[0] = 8'h02;
        init_mem();
        start_run(t);
        run_window(t, 400, -1, -1, -1, -1, -1);
        check_eq("t2_done_cyc", 32'(done_rel), 32'd7);
        check_eq("t2_valid", 32'(done_valid), 32'd0);
        check_eq("t2_fail_idx", 32'(done_fidx), 32'd0);
        check_eq("t2_nwr", 32'(wr_cyc.size()), 32'd0);

        // Reference PRGA over identity S: every byte decrypts to a space
        for (int a = 0; a < 256; a++) ms[a] = 8'(a);
        mi = 8'h00; mj = 8'h00;
        for (int k = 0; k < 32; k++) begin
            mi = mi + 8'd1;
            mj = mj + ms[mi];
            tmp = ms[mi]; ms[mi] = ms[mj]; ms[mj] = tmp;
            tmp = ms[mi] + ms[mj];
            m_rom[k] = ms[tmp] ^ 8'h20;
        end
        init_mem();
        start_run(t);
        run_window(t, 400, -1, -1, -1, -1, -1);
        check_eq("t3_done_cyc", 32'(done_rel), 32'd193);
        check_eq("t3_valid", 32'(done_valid), 32'd1);
        check_eq("t3_nwr", 32'(wr_cyc.size()), 32'd32);
        bad = 0;
        for (int k = 0; k < wr_cyc.size(); k++)
            if (wr_dat[k] != 8'h20 || wr_adr[k] != 5'(k) || wr_cyc[k] != 6 + 6 * k) bad++;
        check_eq("t3_wr_bad", 32'(bad), 32'd0);
        @(negedge clk);
        bad = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== ms[a]) bad++;
        check_eq("t3_s_final", 32'(bad), 32'd0);

        // Abort mid-run
        init_mem();
        start_run(t);
        run_window(t, 200, -1, 50, -1, 51, 51);
        check_eq("t4_busy_51", 32'(snap_busy), 32'd0);
        check_eq("t4_late_wr", 32'(late_wr), 32'd0);
        check_eq("t4_done_cnt", 32'(done_cnt), 32'd0);
        check_eq("t4_valid", 32'(valid), 32'd0);

        // Start and abort together in IDLE: nothing starts
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        check_eq("idle_abort_busy", 32'(busy), 32'd0);

        // Synchronous reset in the middle of a run, then a clean run
        init_mem();
        start_run(t);
        run_window(t, 35, -1, -1, 30, 31, -1);
        check_eq("t5_rst_outs", 32'(snap_nz), 32'd0);
        check_eq("t5_done_cnt", 32'(done_cnt), 32'd0);
        init_mem();
        start_run(t);
        run_window(t, 400, -1, -1, -1, -1, -1);
        check_eq("t5_done_cyc", 32'(done_rel), 32'd193);
        check_eq("t5_valid", 32'(done_valid), 32'd1);
        check_eq("t5_nwr", 32'(wr_cyc.size()), 32'd32);

        // Start pulse while busy is ignored
        init_mem();
        start_run(t);
        run_window(t, 400, 20, -1, -1, -1, -1);
        check_eq("t6_done_cyc", 32'(done_rel), 32'd193);
        check_eq("t6_valid", 32'(done_valid), 32'd1);
        @(negedge clk);
        check_eq("t6_idle_after", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
